// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared op encoding and default sizes for the logic unit
package logic_unit_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_ANDN = 3'b111
    } logic_op_t;

endpackage

// File: rtl/logic_unit_op.sv
// rtl/logic_unit_op.sv - combinational bitwise op mux for the logic unit
module logic_unit_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic_op_t        op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = inp1 & inp2;
            OP_OR:   result = inp1 | inp2;
            OP_XOR:  result = inp1 ^ inp2;
            OP_NAND: result = ~(inp1 & inp2);
            OP_NOR:  result = ~(inp1 | inp2);
            OP_XNOR: result = ~(inp1 ^ inp2);
            OP_NOT:  result = ~inp1;
            OP_ANDN: result = inp1 & ~inp2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - single-stage handshaked logic unit with result flags and consume counter
// Optional parity output enabled by LOGIC_UNIT_PARITY_EN.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             consume;

    logic_unit_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .op     (logic_op_t'(op)),
        .inp1   (inp1),
        .inp2   (inp2),
        .result (result)
    );

    // The output slot frees up in the same cycle it is consumed.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        count_d     = count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = result;
            zero_d      = ~|result;
            ones_d      = &result;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        if (consume) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign op_count  = count_q;

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit.sv
// tb/tb_logic_unit.sv - randomized and directed self-checking bench for logic_unit
module tb_logic_unit;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  inp1 = '0;
    logic [W-1:0]  inp2 = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out;
    logic          zero;
    logic          ones;
    logic [CW-1:0] op_count;
`ifdef LOGIC_UNIT_PARITY_EN
    logic          parity;
`endif

    int total = 0;
    int bad   = 0;

    bit           m_valid = 1'b0;
    logic [W-1:0] m_out   = '0;
    int           m_count = 0;

    logic_unit #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .inp1      (inp1),
        .inp2      (inp2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .ones      (ones),
        .op_count  (op_count)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lu_ref(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            3:       return ~(a & b);
            4:       return ~(a | b);
            5:       return ~(a ^ b);
            6:       return ~a;
            default: return a & ~b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".op_count"}, 64'(op_count), 64'(m_count % 16));
        if (m_valid) begin
            chk({tag, ".out"},  64'(out),  64'(m_out));
            chk({tag, ".zero"}, 64'(zero), 64'(m_out == '0));
            chk({tag, ".ones"}, 64'(ones), 64'(m_out == '1));
`ifdef LOGIC_UNIT_PARITY_EN
            chk({tag, ".parity"}, 64'(parity), 64'(^m_out));
`endif
        end
    endtask

    // Drives one cycle starting just after a falling edge and checks after the next falling edge.
    task automatic step(input string tag, input bit v, input bit r, input int o,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        bit con;
        in_valid  = v;
        out_ready = r;
        op        = 3'(o);
        inp1      = a;
        inp2      = b;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || r));
        acc = v && (!m_valid || r);
        con = m_valid && r;
        @(posedge clk);
        if (con) m_count++;
        if (acc) begin
            m_out   = lu_ref(o, a, b);
            m_valid = 1'b1;
        end else if (con) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out   = '0;
        m_count = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out"},       64'(out),       64'd0);
        chk({tag, ".zero"},      64'(zero),      64'd0);
        chk({tag, ".ones"},      64'(ones),      64'd0);
        chk({tag, ".op_count"},  64'(op_count),  64'd0);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
`ifdef LOGIC_UNIT_PARITY_EN
        chk({tag, ".parity"},    64'(parity),    64'd0);
`endif
    endtask

    initial begin : main
        logic [W-1:0] held;
        logic [W-1:0] stream_exp [8];
        int base;

        stream_exp = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                       16'h0000, 16'h0000, 16'h0FF0, 16'hF00F};

        // reset held across clock edges, then released
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        model_reset();

        // first accept right after release
        step("and_acc", 1'b1, 1'b1, 0, 16'h000B, 16'h000D);
        chk("and_out",  64'(out),  64'h0009);
        chk("and_zero", 64'(zero), 64'd0);
        chk("and_ones", 64'(ones), 64'd0);
        step("and_drain", 1'b0, 1'b1, 0, '0, '0);
        chk("and_count", 64'(op_count), 64'd1);

        step("nand_acc", 1'b1, 1'b1, 3, 16'hFFFF, 16'hFFFF);
        chk("nand_out",  64'(out),  64'h0000);
        chk("nand_zero", 64'(zero), 64'd1);
        step("nor_acc", 1'b1, 1'b1, 4, 16'h0000, 16'h0000);
        chk("nor_out",  64'(out),  64'hFFFF);
        chk("nor_ones", 64'(ones), 64'd1);
        step("nor_drain", 1'b0, 1'b1, 0, '0, '0);

        // stall with changing operands
        step("stall_acc", 1'b1, 1'b0, 2, 16'h1234, 16'h00FF);
        held = out;
        base = m_count;
        for (int i = 0; i < 5; i++) begin
            step("stall", 1'b1, 1'b0, int'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            chk("stall_out_hold", 64'(out), 64'(held));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_count", 64'(op_count), 64'(base % 16));
        end
        step("stall_release", 1'b0, 1'b1, 0, '0, '0);
        chk("stall_consumed", 64'(op_count), 64'((base + 1) % 16));

        // back-to-back stream over every op
        base = m_count;
        for (int i = 0; i < 8; i++) begin
            step("stream", 1'b1, 1'b1, i, 16'hF00F, 16'h0FF0);
            chk("stream_out", 64'(out), 64'(stream_exp[i]));
        end
        step("stream_drain", 1'b0, 1'b1, 0, '0, '0);
        chk("stream_count", 64'(op_count), 64'((base + 8) % 16));

        // random traffic with random backpressure
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end

`ifdef LOGIC_UNIT_PARITY_EN
        step("par_acc", 1'b1, 1'b1, 1, 16'h0007, 16'h0000);
        chk("par_out", 64'(out), 64'h0007);
        chk("par_bit", 64'(parity), 64'd1);
`endif

        // asynchronous reset while a result is stalled
        step("areset_acc", 1'b1, 1'b0, 1, 16'h00F0, 16'h0F00);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("areset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // counter wrap after 17 consumes
        for (int i = 0; i < 17; i++) begin
            step("wrap", 1'b1, 1'b1, int'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        end
        step("wrap_drain", 1'b0, 1'b1, 0, '0, '0);
        chk("wrap_count", 64'(op_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result bit width (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the completed-operation counter.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a clk edge.
REQ-007 SHALL have port op  input  3  operation select, per the REQ-013 table.
REQ-008 SHALL have ports inp1, inp2  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result when out_valid and out_ready are both high.
REQ-011 SHALL have ports out  output  WIDTH  result; zero  output  1  result all-zeros; ones  output  1  result all-ones.
REQ-012 SHALL have port op_count  output  CNT_W  number of results consumed downstream.

Function
REQ-013 SHALL compute: 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR; 110 NOT inp1 (inp2 ignored); 111 ANDN (inp1 & ~inp2).
REQ-014 SHALL register the result, zero and ones together on acceptance, giving a latency of exactly 1 cycle from accept to out_valid.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally, so back-to-back accepts sustain one result per cycle.
REQ-016 SHALL hold out, zero, ones and out_valid stable while out_valid=1 and out_ready=0, regardless of the inputs.
REQ-017 SHALL clear out_valid after a downstream consume when no new accept occurs in the same cycle.
REQ-018 SHALL, on a simultaneous consume and accept, load the new result and keep out_valid=1 with no bubble.
REQ-019 SHALL increment op_count by 1 on each consume and wrap from 2^CNT_W-1 to 0.
REQ-020 SHALL ignore op, inp1 and inp2 in any cycle without an accept.

Reset
REQ-021 SHALL, while rst=1, force out_valid=0, out=0, zero=0, ones=0 and op_count=0 immediately, independent of clk.
REQ-022 SHALL drive in_ready=1 during and after reset.
REQ-023 SHALL discard a pending result if reset asserts mid-transfer; no consume is counted.
REQ-024 SHALL resume normal accepts on the first rising clk edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro LOGIC_UNIT_PARITY_EN defined, add port parity  output  1 (XOR-reduce of the result), registered with out, reset to 0 and held under stall.
REQ-026 SHALL, without LOGIC_UNIT_PARITY_EN, omit the parity port and its logic entirely, leaving all other behaviour identical.

Structure
REQ-027 SHALL place the op encoding constants/enum (logic_op_t: OP_AND ... OP_ANDN) and the default WIDTH in shared package logic_unit_pkg.
REQ-028 SHALL implement the combinational op mux in sub-module logic_unit_op (inputs op, inp1, inp2; output result), with the handshake, flag and counter registers kept in logic_unit.

Verification
REQ-029 SHALL cover this case: reset held, then released; accept op=000, inp1=0x000B, inp2=0x000D, out_ready=1 -> next cycle out=0x0009, zero=0, ones=0; op_count=1 after consume.
REQ-030 SHALL cover this case: op=011 (NAND), inp1=0xFFFF, inp2=0xFFFF -> out=0x0000, zero=1; op=100 (NOR), inp1=0x0000, inp2=0x0000 -> out=0xFFFF, ones=1.
REQ-031 SHALL cover this case: out_ready=0 for 5 cycles after a result while the operands change -> out is stable, in_ready=0, op_count is unchanged; then out_ready=1 -> one consume counted.
REQ-032 SHALL cover this case: streaming 8 accepts with out_ready=1 every cycle and ops 000..111 on inp1=0xF00F, inp2=0x0FF0 -> 8 results on consecutive cycles matching the REQ-013 table, op_count=8.
REQ-033 SHALL cover this case: rst asserted mid-stall with out_valid=1 -> out_valid=0, out=0 and op_count=0 in the same cycle, without waiting for clk.
REQ-034 SHALL cover this case: with CNT_W=4, 17 consumes -> op_count=1 (wrap); with LOGIC_UNIT_PARITY_EN, out=0x0007 -> parity=1.
